// File: rtl/inv_shiftrow_stream.sv
// Column-serial AES InvShiftRows: buffers a 4x4 state one 32-bit column at a time
// and emits it with row r rotated right by r. Optional macro: INV_SHIFTROW_LAST_CHK_EN.
module inv_shiftrow_stream #(
  parameter int DOUBLE_BUF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last
`ifdef INV_SHIFTROW_LAST_CHK_EN
  ,
  input  logic        s_last,
  output logic        err
`endif
);

  // Handshake: a beat transfers on the rising edge where valid && ready; valid
  // never depends on ready, and both ready and valid come from registered state.
  logic [31:0] mem [2][4];
  logic [1:0]  full;
  logic        wr_bank;
  logic        rd_bank;
  logic [1:0]  wr_col;
  logic [1:0]  rd_col;
  logic        wr_fire;
  logic        rd_fire;

  assign s_ready = !full[wr_bank];
  assign m_valid = full[rd_bank];
  assign m_last  = m_valid && (rd_col == 2'd3);
  assign wr_fire = s_valid && s_ready;
  assign rd_fire = m_valid && m_ready;

  // A write and a read never touch the same bank's full flag in one cycle:
  // the write needs it clear, the read needs it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_col  <= 2'd0;
      rd_col  <= 2'd0;
    end else begin
      if (wr_fire) begin
        wr_col <= wr_col + 2'd1;
        if (wr_col == 2'd3) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= (DOUBLE_BUF != 0) ? ~wr_bank : 1'b0;
        end
      end
      if (rd_fire) begin
        rd_col <= rd_col + 2'd1;
        if (rd_col == 2'd3) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= (DOUBLE_BUF != 0) ? ~rd_bank : 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_col] <= s_data;
  end

  // Row r of output column c comes from stored column (c - r) mod 4.
  always_comb begin
    logic [1:0] src;
    src    = 2'd0;
    m_data = '0;
    if (m_valid) begin
      for (int r = 0; r < 4; r++) begin
        src = rd_col - 2'(r);
        m_data[31-8*r -: 8] = mem[rd_bank][src][31-8*r -: 8];
      end
    end
  end

`ifdef INV_SHIFTROW_LAST_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (wr_fire && (s_last != (wr_col == 2'd3))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_inv_shiftrow_stream.sv
// Self-checking bench for inv_shiftrow_stream: random blocks compared against
// a matrix-level InvShiftRows model, plus reset, latency, backpressure checks.
module tb_inv_shiftrow_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_last;
`ifdef INV_SHIFTROW_LAST_CHK_EN
  logic        s_last = 1'b0;
  logic        err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  int          obs_cyc[$];

  inv_shiftrow_stream #(.DOUBLE_BUF(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
`ifdef INV_SHIFTROW_LAST_CHK_EN
    ,
    .s_last  (s_last),
    .err     (err)
`endif
  );

  // ---------------- clock / reset / monitor ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      obs_q.push_back({m_last, m_data});
      obs_cyc.push_back(cyc);
    end
  end

  // ---------------- reference model ----------------
  // State as a 4x4 byte matrix st[row][col]; InvShiftRows moves st[r][c] to column (c+r)%4.
  task automatic model_block(input logic [31:0] blk [4]);
    logic [7:0] st [4][4];
    logic [7:0] o  [4][4];
    logic [31:0] col;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = blk[c][31-8*r -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[r][(c + r) % 4] = st[r][c];
    for (int c = 0; c < 4; c++) begin
      col = {o[0][c], o[1][c], o[2][c], o[3][c]};
      exp_q.push_back({(c == 3), col});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_beat(input logic [31:0] d, input bit last, output int waits);
    bit ok;
    s_valid = 1'b1;
    s_data  = d;
`ifdef INV_SHIFTROW_LAST_CHK_EN
    s_last  = last;
`else
    if (last) ok = 1'b0;
`endif
    waits = 0;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      if (!ok) waits++;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL drive_timeout: s_ready stayed %0b, required 1", s_ready);
    end
  endtask

  task automatic send_block(input logic [31:0] blk [4], output int stalls);
    int w;
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      drive_beat(blk[i], (i == 3), w);
      stalls += w;
    end
    s_valid = 1'b0;
  endtask

  task automatic rand_block(output logic [31:0] blk [4]);
    for (int i = 0; i < 4; i++) blk[i] = $urandom;
  endtask

  task automatic wait_outputs(input int n, input int budget);
    for (int k = 0; k < budget && obs_q.size() < n; k++) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [31:0] fixed_blk [4];
  logic [31:0] fixed_exp [4];

  // ---------------- tests ----------------
  task automatic test_reset();
    int st;
    n_checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== 32'h0 || m_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: s_ready=%b m_valid=%b m_data=%h m_last=%b, required 1 0 00000000 0",
               s_ready, m_valid, m_data, m_last);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    m_ready = 1'b0;
    send_block(fixed_blk, st);
    n_checks++;
    if (m_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_preload_valid: m_valid=%b required 1", m_valid);
    end
    @(posedge clk); #3 rst = 1'b1;
    #1;
    n_checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== 32'h0 || m_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midcycle: s_ready=%b m_valid=%b m_data=%h m_last=%b, required 1 0 00000000 0",
               s_ready, m_valid, m_data, m_last);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_block();
    int w;
    clear_obs();
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_beat(fixed_blk[i], 1'b0, w);
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_early_valid: m_valid=%b required 0", m_valid);
    end
    drive_beat(fixed_blk[3], 1'b1, w);
    s_valid = 1'b0;
    n_checks++;
    if (m_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_latency: m_valid=%b required 1", m_valid);
    end
    wait_outputs(4, 50);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 4) begin
      n_fail++; $display("FAIL single_count: got %0d columns, required 4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== {(i == 3), fixed_exp[i]}) begin
        n_fail++;
        $display("FAIL single_col%0d: got last=%b data=%h, required last=%b data=%h",
                 i, obs_q[i][32], obs_q[i][31:0], (i == 3), fixed_exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] blk [4];
    int st, total, c0;
    clear_obs();
    m_ready = 1'b1;
    total = 0;
    c0 = cyc;
    for (int b = 0; b < 3; b++) begin
      rand_block(blk);
      model_block(blk);
      send_block(blk, st);
      total += st;
    end
    wait_outputs(12, 60);
    n_checks++;
    if (total != 0) begin
      n_fail++; $display("FAIL stream_stalls: s_ready dropped %0d cycles, required 0", total);
    end
    n_checks++;
    if (obs_q.size() != 12) begin
      n_fail++; $display("FAIL stream_count: got %0d columns, required 12", obs_q.size());
    end else begin
      n_checks++;
      if (obs_cyc[0] != c0 + 4) begin
        n_fail++; $display("FAIL stream_fill: first out at cycle %0d, required %0d", obs_cyc[0], c0 + 4);
      end
      for (int i = 0; i < 12; i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i] || obs_cyc[i] != obs_cyc[0] + i) begin
          n_fail++;
          $display("FAIL stream_col%0d: got %h at cycle %0d, required %h at cycle %0d",
                   i, obs_q[i], obs_cyc[i], exp_q[i], obs_cyc[0] + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] blk [4];
    int st, bad;
    clear_obs();
    m_ready = 1'b0;
    model_block(fixed_blk);
    send_block(fixed_blk, st);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_valid !== 1'b1 || m_data !== 32'h000d0a07 || m_last !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL bp_hold: %0d cycles with m_data=%h not held, required 000d0a07", bad, m_data);
    end
    @(posedge clk); #1;
    rand_block(blk);
    model_block(blk);
    send_block(blk, st);
    n_checks++;
    if (st != 0) begin
      n_fail++; $display("FAIL bp_accept_b: %0d stall cycles, required 0", st);
    end
    @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b0 || m_data !== 32'h000d0a07) begin
      n_fail++; $display("FAIL bp_full: s_ready=%b m_data=%h, required 0 000d0a07", s_ready, m_data);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_outputs(8, 60);
    n_checks++;
    if (obs_q.size() != 8) begin
      n_fail++; $display("FAIL bp_count: got %0d columns, required 8", obs_q.size());
    end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_col%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drained: s_ready=%b m_valid=%b, required 1 0", s_ready, m_valid);
    end
  endtask

  task automatic test_mid_reset();
    int w, st;
    m_ready = 1'b1;
    drive_beat($urandom, 1'b0, w);
    drive_beat($urandom, 1'b0, w);
    s_valid = 1'b0;
    pulse_reset();
    clear_obs();
    send_block(fixed_blk, st);
    wait_outputs(4, 50);
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 4) begin
      n_fail++; $display("FAIL midrst_count: got %0d columns, required 4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== {(i == 3), fixed_exp[i]}) begin
        n_fail++; $display("FAIL midrst_col%0d: got %h, required %h", i, obs_q[i], {(i == 3), fixed_exp[i]});
      end
    end
  endtask

`ifdef INV_SHIFTROW_LAST_CHK_EN
  task automatic test_last_chk();
    logic [31:0] blk [4];
    int w, st;
    pulse_reset();
    m_ready = 1'b1;
    drive_beat($urandom, 1'b0, w);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL lastchk_pre: err=%b required 0", err);
    end
    drive_beat($urandom, 1'b1, w);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL lastchk_set: err=%b required 1", err);
    end
    drive_beat($urandom, 1'b0, w);
    drive_beat($urandom, 1'b1, w);
    s_valid = 1'b0;
    rand_block(blk);
    send_block(blk, st);
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL lastchk_sticky: err=%b required 1", err);
    end
    pulse_reset();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL lastchk_reset: err=%b required 0", err);
    end
    rand_block(blk);
    send_block(blk, st);
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL lastchk_clean: err=%b required 0", err);
    end
  endtask
`endif

  initial begin
    fixed_blk[0] = 32'h00010203; fixed_blk[1] = 32'h04050607;
    fixed_blk[2] = 32'h08090a0b; fixed_blk[3] = 32'h0c0d0e0f;
    fixed_exp[0] = 32'h000d0a07; fixed_exp[1] = 32'h04010e0b;
    fixed_exp[2] = 32'h0805020f; fixed_exp[3] = 32'h0c090603;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single_block();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
`ifdef INV_SHIFTROW_LAST_CHK_EN
    test_last_chk();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
